// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions and FSM encoding.
package alu_pkg;

  localparam int DW = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;
  localparam logic [3:0] OP_MOD = 4'hA;

  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;
  localparam int F_E = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MUL always iterates; DIV/MOD iterate only with a non-zero divisor.
  function automatic logic is_iterative(input logic [3:0] op, input logic [DW-1:0] b);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Four-step iterative engine shared by MUL (shift-add) and DIV/MOD (restoring, unsigned).
// result/ovf reflect the step being taken this cycle, so they are final while fin is high.
module muldiv_iter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          ovf,
  output logic          fin
);

  logic [2*DW-1:0] acc_q, acc_d, acc_cur;
  logic [DW-1:0]   sreg_q, sreg_d, sreg_cur;
  logic [1:0]      cnt_q;
  logic [2*DW-1:0] mcand;
  logic [DW:0]     rem_sh, rem_sub;
  logic            is_mul;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    is_mul   = (op == OP_MUL);
    acc_cur  = (cnt_q == 2'd0) ? '0 : acc_q;
    sreg_cur = (cnt_q == 2'd0) ? (is_mul ? b : a) : sreg_q;
    // Multiplier bits are consumed LSB first, so the multiplicand weight is 2**step.
    mcand    = {{DW{1'b0}}, a} << cnt_q;
    rem_sh   = {acc_cur[DW-1:0], sreg_cur[DW-1]};
    rem_sub  = rem_sh - {1'b0, b};
    acc_d    = acc_cur;
    sreg_d   = sreg_cur;

    if (is_mul) begin
      acc_d  = acc_cur + (sreg_cur[0] ? mcand : '0);
      sreg_d = {1'b0, sreg_cur[DW-1:1]};
    end else if (rem_sh >= {1'b0, b}) begin
      acc_d  = {{(DW-1){1'b0}}, rem_sub};
      sreg_d = {sreg_cur[DW-2:0], 1'b1};
    end else begin
      acc_d  = {{(DW-1){1'b0}}, rem_sh};
      sreg_d = {sreg_cur[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      acc_q  <= '0;
      sreg_q <= '0;
      cnt_q  <= 2'd0;
    end else if (go) begin
      acc_q  <= acc_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_q + 2'd1;
    end else begin
      cnt_q  <= 2'd0;
    end
  end

  always_comb begin
    fin    = go && (cnt_q == 2'd3);
    ovf    = is_mul && (acc_d[2*DW-1:DW] != '0);
    result = (op == OP_DIV) ? sreg_d : acc_d[DW-1:0];
  end

endmodule

// File: rtl/alu_secuencial.sv
// Sequential ALU: captures operands on start, runs a 1-cycle or 4-cycle calculation,
// then presents registered result/flags with a one-cycle done pulse.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [3:0]       opcode,
  input  logic             start,
  output logic [WIDTH-1:0] outrest,
  output logic [4:0]       outflag,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;

  logic             long_op, calc_fin, go;
  logic [WIDTH-1:0] md_result;
  logic             md_ovf, md_fin;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic [4:0]       flg;
  logic             fc, fv, fe;

  // State register plus operand capture; operands are frozen for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        a_q  <= iA;
        b_q  <= iB;
        op_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_CALC;
      ST_CALC: if (calc_fin) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign long_op  = is_iterative(op_q, b_q);
  assign go       = (state_q == ST_CALC) && long_op;
  assign calc_fin = long_op ? md_fin : 1'b1;

  muldiv_iter u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (md_result),
    .ovf    (md_ovf),
    .fin    (md_fin)
  );

  // Single-cycle datapath and flag generation; iterative ops take the engine's final step.
  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, b_q};
    diff = {1'b0, a_q} - {1'b0, b_q};
    res  = '0;
    fc   = 1'b0;
    fv   = 1'b0;
    fe   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        fc  = sum[WIDTH];
        fv  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        fc  = diff[WIDTH];
        fv  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_SHL: begin
        res = {a_q[WIDTH-2:0], 1'b0};
        fc  = a_q[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a_q[WIDTH-1:1]};
        fc  = a_q[0];
      end
      OP_MUL: begin
        res = md_result;
        fv  = md_ovf;
      end
      OP_DIV, OP_MOD: begin
        if (b_q == '0) fe  = 1'b1;
        else           res = md_result;
      end
      default: fe = 1'b1;
    endcase

    flg      = '0;
    flg[F_E] = fe;
    flg[F_V] = fv;
    flg[F_N] = res[WIDTH-1];
    flg[F_C] = fc;
    flg[F_Z] = (res == '0);
  end

  // Result registers change only when a calculation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outrest <= '0;
      outflag <= '0;
    end else if (state_q == ST_CALC && calc_fin) begin
      outrest <= res;
      outflag <= flg;
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial: directed vector table, multi-cycle corner
// sequences and random operations against an arithmetic reference model.
module tb_alu_secuencial;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] iA, iB, opcode;
  logic       start;
  logic [3:0] outrest;
  logic [4:0] outflag;
  logic       busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] r;
    logic [4:0] f;
    int         lat;
  } vec_t;

  vec_t tbl[20];

  always #5 clk = ~clk;

  alu_secuencial #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iA      (iA),
    .iB      (iB),
    .opcode  (opcode),
    .start   (start),
    .outrest (outrest),
    .outflag (outflag),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input int a, input int b, input int op,
                                output logic [3:0] r, output logic [4:0] f, output int lat);
    int sa, sb, res;
    logic e, v, c;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    e = 1'b0; v = 1'b0; c = 1'b0; res = 0; lat = 1;
    case (op)
      0: begin res = a + b; c = (res > 15); v = (sa + sb > 7) || (sa + sb < -8); end
      1: begin res = a - b; c = (a < b);    v = (sa - sb > 7) || (sa - sb < -8); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 15 - a;
      6: begin res = a * 2; c = (a > 7); end
      7: begin res = a / 2; c = (a % 2 == 1); end
      8: begin res = a * b; v = (res > 15); lat = 4; end
      9, 10: begin
        if (b == 0) e = 1'b1;
        else begin
          res = (op == 9) ? a / b : a % b;
          lat = 4;
        end
      end
      default: e = 1'b1;
    endcase
    r = res[3:0];
    f = {e, v, r[3], c, (r == 4'd0)};
  endfunction

  // Issue one op from IDLE (call #1 after a rising edge); inputs are scrambled after accept.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       output logic [3:0] r, output logic [4:0] f, output int lat);
    iA = a; iB = b; opcode = op; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    iA     = 4'($urandom);
    iB     = 4'($urandom);
    opcode = 4'($urandom);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
    r = outrest;
    f = outflag;
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] r, er;
    logic [4:0] f, ef;
    int lat, elat, seen;
    int hits[$];
    logic [3:0] ra, rb, rop;

    tbl[0]  = '{4'd7,  4'd1, OP_ADD, 4'h8, 5'b01100, 1};
    tbl[1]  = '{4'd3,  4'd5, OP_SUB, 4'hE, 5'b00110, 1};
    tbl[2]  = '{4'd9,  4'd0, OP_SHL, 4'h2, 5'b00010, 1};
    tbl[3]  = '{4'd6,  4'd5, OP_MUL, 4'hE, 5'b01100, 4};
    tbl[4]  = '{4'd13, 4'd4, OP_DIV, 4'h3, 5'b00000, 4};
    tbl[5]  = '{4'd13, 4'd4, OP_MOD, 4'h1, 5'b00000, 4};
    tbl[6]  = '{4'd9,  4'd0, OP_DIV, 4'h0, 5'b10001, 1};
    tbl[7]  = '{4'd3,  4'd3, 4'hC,   4'h0, 5'b10001, 1};
    tbl[8]  = '{4'd7,  4'd0, OP_MOD, 4'h0, 5'b10001, 1};
    tbl[9]  = '{4'd5,  4'd0, OP_SHR, 4'h2, 5'b00010, 1};
    tbl[10] = '{4'hF,  4'd0, OP_AND, 4'h0, 5'b00001, 1};
    tbl[11] = '{4'd0,  4'd0, OP_NOT, 4'hF, 5'b00100, 1};
    tbl[12] = '{4'hA,  4'd5, OP_XOR, 4'hF, 5'b00100, 1};
    tbl[13] = '{4'd8,  4'd1, OP_OR,  4'h9, 5'b00100, 1};
    tbl[14] = '{4'd8,  4'd8, OP_ADD, 4'h0, 5'b01011, 1};
    tbl[15] = '{4'd8,  4'd1, OP_SUB, 4'h7, 5'b01000, 1};
    tbl[16] = '{4'hF,  4'hF, OP_MUL, 4'h1, 5'b01000, 4};
    tbl[17] = '{4'hF,  4'd1, OP_DIV, 4'hF, 5'b00100, 4};
    tbl[18] = '{4'd3,  4'd7, OP_MOD, 4'h3, 5'b00000, 4};
    tbl[19] = '{4'd0,  4'd5, OP_DIV, 4'h0, 5'b00001, 4};

    rst_n = 1'b0; start = 1'b0; iA = '0; iB = '0; opcode = '0;
    #12;
    check("reset_outrest", int'(outrest), 0);
    check("reset_outflag", int'(outflag), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);

    // Directed vectors.
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, r, f, lat);
      check($sformatf("vec%0d_outrest", i), int'(r), int'(tbl[i].r));
      check($sformatf("vec%0d_outflag", i), int'(f), int'(tbl[i].f));
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    // start held across three MULs: done every CALC(4)+DONE(1)+IDLE(1) cycles.
    iA = 4'd6; iB = 4'd5; opcode = OP_MUL; start = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      if (done) hits.push_back(e);
    end
    start = 1'b0;
    check("held_done_count", hits.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("held_done_edge%0d", k), (hits.size() > k) ? hits[k] : -1, 5 + 6 * k);
    check("held_outrest", int'(outrest), 4'hE);
    @(posedge clk); #1;
    check("held_idle_after", int'(busy), 0);

    // Reset during the 2nd CALC cycle of a MUL aborts with no done.
    do_op(4'd7, 4'd1, OP_ADD, r, f, lat);
    check("pre_abort_outrest", int'(r), 8);
    iA = 4'd6; iB = 4'd5; opcode = OP_MUL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_outrest", int'(outrest), 0);
    check("abort_outflag", int'(outflag), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    do_op(4'd2, 4'd2, OP_ADD, r, f, lat);
    check("post_abort_outrest", int'(r), 4);
    check("post_abort_outflag", int'(f), 0);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra  = 4'($urandom_range(15));
      rb  = 4'($urandom_range(15));
      rop = 4'($urandom_range(15));
      if (i % 4 == 0) rb = 4'd0;
      model(int'(ra), int'(rb), int'(rop), er, ef, elat);
      do_op(ra, rb, rop, r, f, lat);
      check($sformatf("rnd%0d_op%0h_%0h_%0h_outrest", i, rop, ra, rb), int'(r), int'(er));
      check($sformatf("rnd%0d_op%0h_%0h_%0h_outflag", i, rop, ra, rb), int'(f), int'(ef));
      check($sformatf("rnd%0d_op%0h_latency", i, rop), lat, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
